// File: rtl/mips_mem_pkg.sv
// Shared definitions for the single-port memory arbiter: FSM state encoding
// and the legal bounds of the memory read latency.
package mips_mem_pkg;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_W       = 3;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_IWAIT = 3'd1,
    ST_DATA  = 3'd2,
    ST_DWAIT = 3'd3,
    ST_EXEC  = 3'd4,
    ST_HALT  = 3'd5
  } state_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory read latency countdown: load with the latency on issue, decrement
// while waiting; done marks the cycle in which read data is valid.
module mem_lat_counter
  import mips_mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [LAT_W-1:0] count_q;
  logic [LAT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == LAT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises one instruction fetch and at most one data access per CPU
// instruction onto a single memory port, then strobes the CPU forward.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        cpu_active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        clock_enable,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  output logic        halted,
  output logic        protocol_error,
  output logic [31:0] stall_count
);

  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY);

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, data_d;
  logic        perr_q, perr_d;
  logic [31:0] stall_q, stall_d;

  logic        cnt_load, cnt_dec, cnt_done;
  logic        mem_read_c, mem_write_c;
  logic [31:0] mem_address_c, mem_writedata_c;

  mem_lat_counter u_lat (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LAT_LOAD),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    data_d          = data_q;
    perr_d          = perr_q;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    mem_address_c   = '0;
    mem_writedata_c = '0;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          if (!cpu_active) begin
            state_d = ST_HALT;
          end else begin
            mem_read_c    = 1'b1;
            mem_address_c = instr_address;
            cnt_load      = 1'b1;
            state_d       = ST_IWAIT;
          end
        end
      end
      ST_IWAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          instr_d = mem_readdata;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // A simultaneous read request is dropped in favour of the write.
        if (data_write) begin
          mem_write_c     = 1'b1;
          mem_address_c   = data_address;
          mem_writedata_c = data_writedata;
          perr_d          = perr_q | data_read;
          state_d         = ST_EXEC;
        end else if (data_read) begin
          mem_read_c    = 1'b1;
          mem_address_c = data_address;
          cnt_load      = 1'b1;
          state_d       = ST_DWAIT;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_DWAIT: begin
        cnt_dec = 1'b1;
        if (cnt_done) begin
          data_d  = mem_readdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    if (run && (state_q != ST_HALT) && (state_q != ST_EXEC) && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      instr_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      stall_q <= stall_d;
    end
  end

  // Port drives are decoded from the state, so gate them with reset to keep
  // a FETCH-with-run from leaking a read while reset is held.
  assign mem_read       = mem_read_c & ~reset;
  assign mem_write      = mem_write_c & ~reset;
  assign mem_address    = reset ? 32'd0 : mem_address_c;
  assign mem_writedata  = reset ? 32'd0 : mem_writedata_c;
  assign clock_enable   = (state_q == ST_EXEC);
  assign halted         = (state_q == ST_HALT);
  assign instr_readdata = instr_q;
  assign data_readdata  = data_q;
  assign protocol_error = perr_q;
  assign stall_count    = stall_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1, cycles from the mem_read issue cycle to the valid mem_readdata cycle; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port run  input  1  enables issue of a new fetch.
REQ-005 SHALL have port cpu_active  input  1  CPU active flag, sampled in FETCH.
REQ-006 SHALL have ports instr_address  input  32  and instr_readdata  output  32  (CPU fetch port, buffered word).
REQ-007 SHALL have ports data_address  input  32, data_read  input  1, data_write  input  1, data_writedata  input  32, data_readdata  output  32 (CPU data port).
REQ-008 SHALL have port clock_enable  output  1  CPU advance strobe.
REQ-009 SHALL have ports mem_address  output  32, mem_read  output  1, mem_write  output  1, mem_writedata  output  32, mem_readdata  input  32 (single-port memory).
REQ-010 SHALL have ports halted  output  1, protocol_error  output  1 (sticky), stall_count  output  32.

Function
REQ-011 SHALL serialise one instruction fetch and at most one data access per CPU instruction onto the single memory port, using FSM states FETCH, IWAIT, DATA, DWAIT, EXEC, HALT.
REQ-012 FETCH: if run=0, remain in FETCH with no memory access; if cpu_active=0, go to HALT; otherwise assert mem_read with mem_address=instr_address, load the latency counter with MEM_LATENCY, and go to IWAIT.
REQ-013 IWAIT: decrement the counter each cycle; in the cycle the counter reaches 1, register mem_readdata into instr_readdata and go to DATA.
REQ-014 DATA: data_write=1 -> one-cycle mem_write, mem_address=data_address, mem_writedata=data_writedata, then EXEC; data_read=1 only -> mem_read at data_address, load counter, then DWAIT; neither -> EXEC.
REQ-015 DWAIT: same countdown as IWAIT; register mem_readdata into data_readdata, then EXEC.
REQ-016 EXEC: clock_enable=1 for exactly this one cycle, then FETCH; clock_enable SHALL be 0 in every other state.
REQ-017 Cycle counts per instruction: no-data and store take 3+MEM_LATENCY cycles; load takes 3+2*MEM_LATENCY cycles.
REQ-018 data_read=1 and data_write=1 together in DATA -> perform the write only and set protocol_error, which stays set until reset.
REQ-019 mem_address and mem_writedata SHALL be 0 whenever mem_read=0 and mem_write=0; mem_read and mem_write SHALL never both be 1.
REQ-020 instr_readdata and data_readdata SHALL hold their values between captures.
REQ-021 HALT: set halted=1, no memory access, clock_enable=0; leave HALT only on reset.
REQ-022 stall_count SHALL increment in every cycle with run=1, state!=HALT and clock_enable=0, and saturate at 32'hFFFFFFFF.

Reset
REQ-023 reset=1 SHALL immediately force state FETCH, counter 0, and outputs clock_enable, mem_read, mem_write, mem_address, mem_writedata, instr_readdata, data_readdata, halted, protocol_error and stall_count all to 0, including mid-access (an in-flight read is discarded).
REQ-024 After reset deasserts, the first fetch SHALL issue in the first cycle where run=1 and cpu_active=1.

Structure
REQ-025 The state enum and the MEM_LATENCY bounds SHALL live in shared package mips_mem_pkg.
REQ-026 The latency countdown MAY be a sub-module mem_lat_counter (load/decrement/done); everything else SHALL stay in a single module.

Verification
REQ-027 MEM_LATENCY=1, instr 0x24020005 at 0xBFC00000, no data access -> mem_read for 1 cycle at 0xBFC00000, instr_readdata=0x24020005, clock_enable pulses once in cycle 4, repeating every 4 cycles.
REQ-028 Load with data_address=0x00001000 and memory word 0xDEADBEEF -> data_readdata=0xDEADBEEF before the EXEC cycle, 5-cycle instruction, stall_count +4.
REQ-029 Store of 0x12345678 to 0x00000010 -> exactly one mem_write cycle with those address/data, mem_read=0 in that cycle, 4-cycle instruction.
REQ-030 data_read=data_write=1 -> write issued, no read, protocol_error=1 persisting through later instructions until reset.
REQ-031 MEM_LATENCY=3, load -> 9-cycle instruction; reset asserted in DWAIT -> all outputs 0 asynchronously and a fresh FETCH after release.
REQ-032 cpu_active=0 in FETCH -> halted=1, no further mem_read or clock_enable, stall_count frozen.
